sequence_generator_io: RTL and testbench
========================================

Name: sequence_generator_io

Overview:
Serial pattern transmitter. It is the send-side counterpart of the sequence detectors in the sequence_detector_io family.
- On a start request it captures a PAT_W-bit pattern, a repeat count and an inter-repeat gap.
- It drives the pattern MSB-first on a one-bit serial output, one bit per clock, with a qualifying valid flag.
- It supplies stimulus to detector blocks and to the serial I/O path feeding them.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2..16)
CNT_W, 4, width of the repeat-count and gap-length inputs

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request to transmit; sampled only in IDLE
pattern  input  PAT_W  bit pattern; pattern[PAT_W-1] is sent first
repeat_n  input  CNT_W  number of pattern repetitions
gap_len  input  CNT_W  idle cycles inserted between repetitions
o  output  1  serial data bit
o_valid  output  1  o carries a pattern bit this cycle
busy  output  1  transfer in progress; start is ignored
done  output  1  one-cycle pulse at end of transfer

Behaviour:
- All outputs are registered.
- Reset (reset==0, asynchronous): state=IDLE; o=0, o_valid=0, busy=0, done=0; internal shift register and counters cleared.
- Reset asserted mid-transfer aborts immediately. No done pulse is produced. After release the block starts in IDLE.
- States are IDLE, SEND, GAP, DONE.
- IDLE, on a rising edge with start=1:
  - capture pattern into the shift register; capture repeat_n and gap_len.
  - if repeat_n==0: go to DONE; no bits are sent.
  - otherwise: go to SEND; busy=1, o=pattern[PAT_W-1], o_valid=1, all from that edge.
- Latency: start sampled at edge N gives the first bit visible after edge N. The last bit of the last repetition is visible after edge N + (PAT_W*R - 1) + G*(R-1), where R=repeat_n and G=gap_len.
- SEND:
  - shift left one bit per clock; bit counter counts PAT_W-1 down to 0.
  - after the LSB, if repetitions remain and G>0: go to GAP; o=0, o_valid=0, busy stays 1.
  - after the LSB, if repetitions remain and G==0: the MSB of the next repetition is sent on the very next cycle (back-to-back).
  - the shift register reloads from the captured pattern, not from the live pattern input.
  - after the LSB of the last repetition: go to DONE.
- GAP: holds for exactly G cycles, then returns to SEND with the MSB.
- DONE: for one cycle, done=1, busy=0, o_valid=0, o=0. Then go to IDLE.
- A start seen during DONE is ignored; start is only accepted in IDLE on the following cycle.
- start, pattern, repeat_n and gap_len changes while busy or in DONE have no effect.
- o=0 whenever o_valid=0.
- Repeat and gap counters saturate at their CNT_W-bit maximum of 2^CNT_W - 1; there is no wrap.

Decomposition:
- Shared package sequence_io_pkg holds:
  - the state enum (IDLE, SEND, GAP, DONE) as a 2-bit typedef;
  - default constants PAT_W_DEF=4 and CNT_W_DEF=4.
- One natural sub-module: seq_down_counter, a loadable, saturating-at-zero down counter with a zero flag. It is instantiated for the bit, repeat and gap counts.
- The shift register and FSM stay in the top module.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release with start=0 for 5 cycles -> o=0, o_valid=0, busy=0, done=0 throughout.
- Single shot: pattern=4'b1101, repeat_n=1, gap_len=0, start pulse at edge N -> o = 1,1,0,1 with o_valid=1 over cycles N..N+3; done=1 at N+4 only; busy=0 from N+4.
- Repeat with gap: pattern=4'b1001, repeat_n=2, gap_len=2 -> serial 1,0,0,1, then two cycles with o_valid=0, then 1,0,0,1; done on the 11th cycle after start.
- Back-to-back and zero repeat:
  - repeat_n=3, gap_len=0, pattern=4'b0110 -> 12 contiguous valid bits 0110 0110 0110.
  - repeat_n=0 -> done pulse on the cycle after start; o_valid never set.
- Input stability: change pattern to 4'b0000 and pulse start during SEND of 4'b1011 -> the transmitted stream is still 1,0,1,1 with a single done pulse, and no second transfer starts.
- Reset mid-operation: assert reset=0 during the 2nd bit -> outputs go to 0 asynchronously (before the next edge) with no done pulse; after release, a new start transmits correctly from the MSB.

Source files
------------

// File: rtl/sequence_io_pkg.sv
// Shared types and defaults for the serial pattern generator and its counters.
package sequence_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter that sticks at zero; used for bit, repeat and gap counts.
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sequence_generator_io.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, R times,
// with G idle cycles between repetitions, then pulses done for one cycle.
module sequence_generator_io
    import sequence_io_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [CNT_W-1:0] gap_len,
    output logic             o,
    output logic             o_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] gap_len_q, gap_len_d;
    logic             o_q, o_d;
    logic             o_valid_q, o_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_load, bit_dec, bit_zero;
    logic             rep_load, rep_dec, rep_zero;
    logic             gap_load, gap_dec, gap_zero;
    logic [CNT_W-1:0] rep_val, gap_val;

    // Repeat counter holds repetitions still to go after the current one.
    assign rep_val = repeat_n - CNT_W'(1);
    assign gap_val = gap_len_q - CNT_W'(1);

    seq_down_counter #(.W(BIT_W)) u_bit_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (bit_load),
        .load_val_i (BIT_LAST),
        .dec_i      (bit_dec),
        .zero_o     (bit_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_rep_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (rep_load),
        .load_val_i (rep_val),
        .dec_i      (rep_dec),
        .zero_o     (rep_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_gap_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (gap_load),
        .load_val_i (gap_val),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        sr_d      = sr_q;
        gap_len_d = gap_len_q;
        bit_load  = 1'b0;
        bit_dec   = 1'b0;
        rep_load  = 1'b0;
        rep_dec   = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d     = pattern;
                    gap_len_d = gap_len;
                    if (repeat_n == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SEND;
                        sr_d     = pattern;
                        bit_load = 1'b1;
                        rep_load = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!bit_zero) begin
                    sr_d    = {sr_q[PAT_W-2:0], 1'b0};
                    bit_dec = 1'b1;
                end else if (rep_zero) begin
                    state_d = DONE;
                end else begin
                    rep_dec = 1'b1;
                    if (gap_len_q != '0) begin
                        state_d  = GAP;
                        gap_load = 1'b1;
                    end else begin
                        sr_d     = pat_q;
                        bit_load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_d  = SEND;
                    sr_d     = pat_q;
                    bit_load = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        o_valid_d = (state_d == SEND);
        o_d       = o_valid_d & sr_d[PAT_W-1];
        busy_d    = (state_d == SEND) || (state_d == GAP);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            sr_q      <= '0;
            gap_len_q <= '0;
            o_q       <= 1'b0;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            sr_q      <= sr_d;
            gap_len_q <= gap_len_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sequence_generator_io.sv
// Randomized scoreboard bench for sequence_generator_io: expected bit/done events
// are computed from the transfer parameters and matched by an independent monitor.
module tb_sequence_generator_io;

    localparam int PW = 4;
    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic          start;
    logic [PW-1:0] pattern;
    logic [CW-1:0] repeat_n;
    logic [CW-1:0] gap_len;
    logic          o;
    logic          o_valid;
    logic          busy;
    logic          done;

    sequence_generator_io #(.PAT_W(PW), .CNT_W(CW)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .pattern  (pattern),
        .repeat_n (repeat_n),
        .gap_len  (gap_len),
        .o        (o),
        .o_valid  (o_valid),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        int cyc;
        bit is_done;
        bit b;
    } ev_t;

    ev_t q[$];
    int  cyc       = 0;
    int  n_chk     = 0;
    int  n_fail    = 0;
    int  busy_from = 1;
    int  busy_to   = 0;
    int  done_cyc  = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: the value visible after posedge k is sampled at the following negedge with cyc==k.
    always @(negedge clock) begin
        ev_t ev;
        if (reset) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                ev = q.pop_front();
                check("event_cycle_missed", cyc, ev.cyc);
            end
            check("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_to));
            if (!o_valid) check("o_zero_when_invalid", int'(o), 0);
            if (o_valid || done) begin
                if (q.size() == 0) begin
                    check("unexpected_output", int'({o_valid, done}), 0);
                end else begin
                    ev = q.pop_front();
                    check("event_cycle", cyc, ev.cyc);
                    check("done_flag", int'(done), int'(ev.is_done));
                    check("valid_flag", int'(o_valid), int'(!ev.is_done));
                    if (!ev.is_done) check("data_bit", int'(o), int'(ev.b));
                end
            end
        end
    end

    // Reference model: start sampled at edge n, repetition r starts at n + r*(PW+g).
    task automatic issue(input logic [PW-1:0] p, input int r, input int g);
        int  n;
        ev_t ev;
        n        = cyc + 1;
        pattern  = p;
        repeat_n = CW'(r);
        gap_len  = CW'(g);
        start    = 1'b1;
        for (int ri = 0; ri < r; ri++) begin
            for (int bi = 0; bi < PW; bi++) begin
                ev.cyc     = n + ri * (PW + g) + bi;
                ev.is_done = 1'b0;
                ev.b       = p[PW-1-bi];
                q.push_back(ev);
            end
        end
        done_cyc   = n + r * PW + ((r > 0) ? g * (r - 1) : 0);
        ev.cyc     = done_cyc;
        ev.is_done = 1'b1;
        ev.b       = 1'b0;
        q.push_back(ev);
        busy_from = n;
        busy_to   = (r == 0) ? n - 1 : done_cyc - 1;
    endtask

    // mode 0: quiet inputs; 1: random input churn; 2: pattern forced to 0 with start held.
    task automatic run_xfer(input int mode);
        while (cyc <= done_cyc) begin
            @(negedge clock);
            if (cyc <= done_cyc) begin
                case (mode)
                    1: begin
                        start    = 1'($urandom_range(0, 1));
                        pattern  = PW'($urandom);
                        repeat_n = CW'($urandom);
                        gap_len  = CW'($urandom);
                    end
                    2: begin
                        start   = 1'b1;
                        pattern = '0;
                    end
                    default: start = 1'b0;
                endcase
            end else begin
                start = 1'b0;
            end
        end
        check("queue_drained", q.size(), 0);
    endtask

    task automatic xfer(input logic [PW-1:0] p, input int r, input int g, input int mode);
        issue(p, r, g);
        run_xfer(mode);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        pattern  = '0;
        repeat_n = '0;
        gap_len  = '0;

        repeat (3) begin
            @(negedge clock);
            check("rst_o", int'(o), 0);
            check("rst_o_valid", int'(o_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("idle_o_valid", int'(o_valid), 0);
            check("idle_done", int'(done), 0);
        end

        xfer(4'b1101, 1, 0, 0);
        xfer(4'b1001, 2, 2, 0);
        xfer(4'b0110, 3, 0, 0);
        xfer(4'b0101, 0, 3, 0);
        xfer(4'b1011, 1, 0, 2);
        xfer(4'b1110, 2, 1, 1);

        // Abort during the second bit; outputs must clear before the next edge.
        issue(4'b1011, 1, 0);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_o", int'(o), 0);
        check("abort_o_valid", int'(o_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        q.delete();
        busy_from = 1;
        busy_to   = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        xfer(4'b1011, 1, 0, 0);

        xfer(4'b1010, 15, 15, 1);
        xfer(4'b0001, 15, 0, 0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            xfer(PW'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 2)));
        end

        repeat (4) @(negedge clock);
        check("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
